// File: rtl/sub_mod_pkg.sv
// Shared constants for the sub_mod subtract unit.
package sub_mod_pkg;

  localparam int unsigned SUB_MOD_DEFAULT_SIZE = 4;
  localparam int unsigned SUB_MOD_MAX_SIZE     = 64;

  localparam logic [SUB_MOD_MAX_SIZE-1:0] SUB_MOD_SUM_RST = '0;

endpackage

// File: rtl/sub_mod_fa.sv
// sub_fa_cell: one-bit full adder, the repeated cell of the subtract ripple chain.
module sub_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  always_comb begin
    p    = x ^ y;
    s    = p ^ cin;
    cout = (x & y) | (cin & p);
  end

endmodule

// File: rtl/sub_mod.sv
// sub_mod: registered a - b via a ripple chain of a + ~b + 1, one-cycle latency.
// Optional SUB_MOD_OVF_EN adds the registered signed-overflow output ovf.
module sub_mod
  import sub_mod_pkg::*;
#(
  parameter int unsigned size = SUB_MOD_DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            c_out,
  output logic [size-1:0] sum
`ifdef SUB_MOD_OVF_EN
  ,
  output logic            ovf
`endif
);

  if (size < 1 || size > SUB_MOD_MAX_SIZE) begin : g_bad_size
    $error("sub_mod: size must be in 1..%0d", SUB_MOD_MAX_SIZE);
  end

  logic [size:0]   carry;
  logic [size-1:0] diff;

  logic [size-1:0] sum_d, sum_q;
  logic            c_out_d, c_out_q;

  // Inverted b into every cell plus carry-in of 1 forms the two's-complement negate.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < size; i++) begin : g_chain
    sub_fa_cell u_fa (
      .x    (a[i]),
      .y    (~b[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    sum_d   = diff;
    c_out_d = carry[size];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= SUB_MOD_SUM_RST[size-1:0];
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

`ifdef SUB_MOD_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = (a[size-1] != b[size-1]) && (diff[size-1] != a[size-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sub_mod.sv
// Self-checking bench for sub_mod: directed 4-bit vector table, reset/hold sequences,
// and a random 8-bit run against an independent arithmetic reference.
module tb_sub_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a4, b4, sum4;
  logic       c4;
  logic [7:0] a8, b8, sum8;
  logic       c8;
`ifdef SUB_MOD_OVF_EN
  logic       ovf4, ovf8;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  sub_mod #(.size(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .a     (a4),
    .b     (b4),
    .c_out (c4),
    .sum   (sum4)
`ifdef SUB_MOD_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  sub_mod #(.size(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .a     (a8),
    .b     (b8),
    .c_out (c8),
    .sum   (sum8)
`ifdef SUB_MOD_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_sum;
    logic       exp_c;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] a, logic [3:0] b,
                              logic [3:0] s, logic c, logic o);
    vec_t v;
    v.rst = r; v.a = a; v.b = b; v.exp_sum = s; v.exp_c = c; v.exp_ovf = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b);
    rst = r; a4 = a; b4 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ea, eb;
    logic [7:0] exp_s8;
    logic       exp_c8;
    int         sd;

    rst = 1'b1; a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    // Reset held two edges, then release.
    vecs.push_back(mk(1, 4'd10, 4'd10, 4'h0, 0, 0));
    vecs.push_back(mk(1, 4'd10, 4'd10, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'd10, 4'd10, 4'h0, 1, 0));
    // a=10, b decrementing 9..0; signed -6 - b overflows for b = 3..7.
    vecs.push_back(mk(0, 4'd10, 4'd9,  4'h1, 1, 0));
    vecs.push_back(mk(0, 4'd10, 4'd8,  4'h2, 1, 0));
    vecs.push_back(mk(0, 4'd10, 4'd7,  4'h3, 1, 1));
    vecs.push_back(mk(0, 4'd10, 4'd6,  4'h4, 1, 1));
    vecs.push_back(mk(0, 4'd10, 4'd5,  4'h5, 1, 1));
    vecs.push_back(mk(0, 4'd10, 4'd4,  4'h6, 1, 1));
    vecs.push_back(mk(0, 4'd10, 4'd3,  4'h7, 1, 1));
    vecs.push_back(mk(0, 4'd10, 4'd2,  4'h8, 1, 0));
    vecs.push_back(mk(0, 4'd10, 4'd1,  4'h9, 1, 0));
    vecs.push_back(mk(0, 4'd10, 4'd0,  4'hA, 1, 0));
    // b wraps to 15 and keeps decrementing: borrow.
    vecs.push_back(mk(0, 4'd10, 4'd15, 4'hB, 0, 0));
    vecs.push_back(mk(0, 4'd10, 4'd14, 4'hC, 0, 0));
    vecs.push_back(mk(0, 4'd10, 4'd13, 4'hD, 0, 0));
    vecs.push_back(mk(0, 4'd10, 4'd12, 4'hE, 0, 0));
    vecs.push_back(mk(0, 4'd10, 4'd11, 4'hF, 0, 0));
    // Extremes.
    vecs.push_back(mk(0, 4'd0,  4'd1,  4'hF, 0, 0));
    vecs.push_back(mk(0, 4'd15, 4'd0,  4'hF, 1, 0));
    vecs.push_back(mk(0, 4'd15, 4'd15, 4'h0, 1, 0));
    vecs.push_back(mk(0, 4'd0,  4'd0,  4'h0, 1, 0));
    // Signed overflow cases.
    vecs.push_back(mk(0, 4'd7,  4'd15, 4'h8, 0, 1));
    vecs.push_back(mk(0, 4'd8,  4'd1,  4'h7, 1, 1));
    vecs.push_back(mk(0, 4'd3,  4'd2,  4'h1, 1, 0));
    vecs.push_back(mk(0, 4'd10, 4'd12, 4'hE, 0, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_sum", i), 64'(sum4), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 64'(c4), 64'(vecs[i].exp_c));
`ifdef SUB_MOD_OVF_EN
      check($sformatf("vec%0d_ovf", i), 64'(ovf4), 64'(vecs[i].exp_ovf));
`endif
    end

    // Outputs must hold between edges: change inputs mid-cycle, expect 10-12 result.
    a4 = 4'd5; b4 = 4'd1;
    #3;
    check("hold_sum", 64'(sum4), 64'h0E);
    check("hold_cout", 64'(c4), 64'd0);

    // Mid-stream reset: 10-3 presented while rst is high must not appear.
    step(0, 4'd9, 4'd2);
    check("pre_rst_sum", 64'(sum4), 64'd7);
    step(1, 4'd10, 4'd3);
    check("rst_flight_sum", 64'(sum4), 64'd0);
    check("rst_flight_cout", 64'(c4), 64'd0);
`ifdef SUB_MOD_OVF_EN
    check("rst_flight_ovf", 64'(ovf4), 64'd0);
`endif
    step(0, 4'd10, 4'd3);
    check("rst_release_sum", 64'(sum4), 64'd7);
    check("rst_release_cout", 64'(c4), 64'd1);
`ifdef SUB_MOD_OVF_EN
    check("rst_release_ovf", 64'(ovf4), 64'd1);
`endif

    // Random 8-bit vectors against plain arithmetic.
    for (int i = 0; i < 1000; i++) begin
      ea = 8'($urandom_range(0, 255));
      eb = 8'($urandom_range(0, 255));
      a8 = ea; b8 = eb;
      @(posedge clk); #1;
      exp_s8 = ea - eb;
      exp_c8 = (ea >= eb);
      check($sformatf("rnd%0d_sum a=%0d b=%0d", i, ea, eb), 64'(sum8), 64'(exp_s8));
      check($sformatf("rnd%0d_cout", i), 64'(c8), 64'(exp_c8));
`ifdef SUB_MOD_OVF_EN
      sd = int'($signed(ea)) - int'($signed(eb));
      check($sformatf("rnd%0d_ovf", i), 64'(ovf8), 64'((sd > 127 || sd < -128) ? 1 : 0));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
